// File: rtl/proc_pkg.sv
// Shared types and constants for the 10-bit processor datapath and sequencer.
package proc_pkg;

    localparam int unsigned DATA_W  = 10;
    localparam int unsigned RADDR_W = 2;
    localparam int unsigned OPC_W   = 4;
    localparam int unsigned ALU_W   = 3;
    localparam int unsigned STEP_W  = 2;

    // Instruction word fields: opcode | Rx | Ry | spare (immediate low bits for ADDI)
    localparam int unsigned OPC_MSB = 9;
    localparam int unsigned OPC_LSB = 6;
    localparam int unsigned RX_MSB  = 5;
    localparam int unsigned RX_LSB  = 4;
    localparam int unsigned RY_MSB  = 3;
    localparam int unsigned RY_LSB  = 2;
    localparam int unsigned IMM_MSB = 3;
    localparam int unsigned IMM_LSB = 0;
    localparam int unsigned IMM_W   = IMM_MSB - IMM_LSB + 1;

    typedef enum logic [OPC_W-1:0] {
        OP_LOAD = 4'b0000,
        OP_COPY = 4'b0001,
        OP_ADD  = 4'b0010,
        OP_SUB  = 4'b0011,
        OP_INV  = 4'b0100,
        OP_AND  = 4'b0101,
        OP_OR   = 4'b0110,
        OP_XOR  = 4'b0111,
        OP_ADDI = 4'b1000
    } opcode_e;

    typedef enum logic [ALU_W-1:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_INV = 3'b010,
        ALU_AND = 3'b011,
        ALU_OR  = 3'b100,
        ALU_XOR = 3'b101
    } alu_op_e;

    typedef enum logic [STEP_W-1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } step_e;

    // ALU select for the two-operand register ops
    function automatic alu_op_e alu_of(input opcode_e op);
        alu_op_e sel;
        sel = ALU_ADD;
        case (op)
            OP_ADD:  sel = ALU_ADD;
            OP_SUB:  sel = ALU_SUB;
            OP_AND:  sel = ALU_AND;
            OP_OR:   sel = ALU_OR;
            OP_XOR:  sel = ALU_XOR;
            default: sel = ALU_ADD;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/step_counter.sv
// Two-bit timestep counter with synchronous clear (priority) and count enable.
module step_counter
    import proc_pkg::*;
(
    input  logic              clk,
    input  logic              clear,
    input  logic              enable,
    output logic [STEP_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/step_sequencer.sv
// Instruction sequencer: latches IR on EXEC in T0, then decodes TIME/IR into bus strobes.
// Build option: define SEQ_ADDI_EN to execute opcode 1000 as ADDI (otherwise it is illegal).
module step_sequencer
    import proc_pkg::*;
(
    input  logic               CLK,
    input  logic               RST,
    input  logic               EXEC,
    input  logic [DATA_W-1:0]  DIN,
    output logic [DATA_W-1:0]  IR_Q,
    output logic [STEP_W-1:0]  TIME,
    output logic               DONE,
    output logic               EXT_OE,
    output logic               IMM_OE,
    output logic [DATA_W-1:0]  IMM,
    output logic               RF_OE,
    output logic [RADDR_W-1:0] RF_RADDR,
    output logic               RF_WE,
    output logic [RADDR_W-1:0] RF_WADDR,
    output logic               A_LD,
    output logic               G_LD,
    output logic               G_OE,
    output logic [ALU_W-1:0]   ALU_OP
);

    logic [DATA_W-1:0]  ir;
    logic [STEP_W-1:0]  step_cnt;
    step_e              step;
    opcode_e            opcode;
    logic [RADDR_W-1:0] rx;
    logic [RADDR_W-1:0] ry;
    logic               fetch;
    logic               busy;

    logic               done;
    logic               ext_oe;
    logic               imm_oe;
    logic               rf_oe;
    logic               rf_we;
    logic               a_ld;
    logic               g_ld;
    logic               g_oe;
    logic [RADDR_W-1:0] raddr;
    logic [RADDR_W-1:0] waddr;
    alu_op_e            alu_op;

    assign step   = step_e'(step_cnt);
    assign opcode = opcode_e'(ir[OPC_MSB:OPC_LSB]);
    assign rx     = ir[RX_MSB:RX_LSB];
    assign ry     = ir[RY_MSB:RY_LSB];
    assign busy   = (step != T0);
    assign fetch  = (step == T0) && EXEC;

    always_ff @(posedge CLK) begin
        if (RST) begin
            ir <= '0;
        end else if (fetch) begin
            ir <= DIN;
        end
    end

    // DONE in the last step clears the counter so the next edge lands in T0
    step_counter u_step_counter (
        .clk    (CLK),
        .clear  (RST || done),
        .enable (fetch || busy),
        .count  (step_cnt)
    );

    always_comb begin
        done   = 1'b0;
        ext_oe = 1'b0;
        imm_oe = 1'b0;
        rf_oe  = 1'b0;
        rf_we  = 1'b0;
        a_ld   = 1'b0;
        g_ld   = 1'b0;
        g_oe   = 1'b0;
        raddr  = '0;
        waddr  = '0;
        alu_op = ALU_ADD;

        if (!RST) begin
            case (opcode)
                OP_LOAD: begin
                    if (step == T1) begin
                        ext_oe = 1'b1;
                        rf_we  = 1'b1;
                        waddr  = rx;
                        done   = 1'b1;
                    end
                end

                OP_COPY: begin
                    if (step == T1) begin
                        rf_oe = 1'b1;
                        raddr = ry;
                        rf_we = 1'b1;
                        waddr = rx;
                        done  = 1'b1;
                    end
                end

                OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                    case (step)
                        T1: begin
                            rf_oe = 1'b1;
                            raddr = rx;
                            a_ld  = 1'b1;
                        end
                        T2: begin
                            rf_oe  = 1'b1;
                            raddr  = ry;
                            g_ld   = 1'b1;
                            alu_op = alu_of(opcode);
                        end
                        T3: begin
                            g_oe  = 1'b1;
                            rf_we = 1'b1;
                            waddr = rx;
                            done  = 1'b1;
                        end
                        default: ;
                    endcase
                end

                OP_INV: begin
                    case (step)
                        T1: begin
                            rf_oe  = 1'b1;
                            raddr  = ry;
                            g_ld   = 1'b1;
                            alu_op = ALU_INV;
                        end
                        T2: begin
                            g_oe  = 1'b1;
                            rf_we = 1'b1;
                            waddr = rx;
                            done  = 1'b1;
                        end
                        default: ;
                    endcase
                end

`ifdef SEQ_ADDI_EN
                OP_ADDI: begin
                    case (step)
                        T1: begin
                            rf_oe = 1'b1;
                            raddr = rx;
                            a_ld  = 1'b1;
                        end
                        T2: begin
                            imm_oe = 1'b1;
                            g_ld   = 1'b1;
                            alu_op = ALU_ADD;
                        end
                        T3: begin
                            g_oe  = 1'b1;
                            rf_we = 1'b1;
                            waddr = rx;
                            done  = 1'b1;
                        end
                        default: ;
                    endcase
                end
`endif

                default: begin
                    // Illegal opcodes retire in T1 with no bus or register activity
                    if (step == T1) begin
                        done = 1'b1;
                    end
                end
            endcase
        end
    end

`ifdef SEQ_ADDI_EN
    assign IMM = {{(DATA_W-IMM_W){1'b0}}, ir[IMM_MSB:IMM_LSB]};
`else
    assign IMM = '0;
`endif

    assign IR_Q     = ir;
    assign TIME     = step_cnt;
    assign DONE     = done;
    assign EXT_OE   = ext_oe;
    assign IMM_OE   = imm_oe;
    assign RF_OE    = rf_oe;
    assign RF_RADDR = raddr;
    assign RF_WE    = rf_we;
    assign RF_WADDR = waddr;
    assign A_LD     = a_ld;
    assign G_LD     = g_ld;
    assign G_OE     = g_oe;
    assign ALU_OP   = alu_op;

endmodule

// File: tb/tb_step_sequencer.sv
// Self-checking bench for step_sequencer: directed vector table, scoreboard of per-step outputs,
// reset-abort sequence and a random instruction stream. Honours SEQ_ADDI_EN like the design.
module tb_step_sequencer;

    logic       clk;
    logic       rst;
    logic       exec;
    logic [9:0] din;
    logic [9:0] ir_q;
    logic [1:0] tstep;
    logic       done;
    logic       ext_oe;
    logic       imm_oe;
    logic [9:0] imm;
    logic       rf_oe;
    logic [1:0] rf_raddr;
    logic       rf_we;
    logic [1:0] rf_waddr;
    logic       a_ld;
    logic       g_ld;
    logic       g_oe;
    logic [2:0] alu_op;

    step_sequencer dut (
        .CLK      (clk),
        .RST      (rst),
        .EXEC     (exec),
        .DIN      (din),
        .IR_Q     (ir_q),
        .TIME     (tstep),
        .DONE     (done),
        .EXT_OE   (ext_oe),
        .IMM_OE   (imm_oe),
        .IMM      (imm),
        .RF_OE    (rf_oe),
        .RF_RADDR (rf_raddr),
        .RF_WE    (rf_we),
        .RF_WADDR (rf_waddr),
        .A_LD     (a_ld),
        .G_LD     (g_ld),
        .G_OE     (g_oe),
        .ALU_OP   (alu_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] tstep;
        logic [9:0] ir;
        logic       done;
        logic       ext_oe;
        logic       imm_oe;
        logic [9:0] imm;
        logic       rf_oe;
        logic [1:0] raddr;
        logic       rf_we;
        logic [1:0] waddr;
        logic       a_ld;
        logic       g_ld;
        logic       g_oe;
        logic [2:0] alu_op;
    } outs_t;

    typedef struct {
        logic [9:0]  din;
        int unsigned lat;
    } vec_t;

    outs_t sb[$];
    outs_t cur;
    int    checks;
    int    errors;
    int    done_seen;

    function automatic outs_t sample();
        outs_t o;
        o.tstep  = tstep;
        o.ir     = ir_q;
        o.done   = done;
        o.ext_oe = ext_oe;
        o.imm_oe = imm_oe;
        o.imm    = imm;
        o.rf_oe  = rf_oe;
        o.raddr  = rf_raddr;
        o.rf_we  = rf_we;
        o.waddr  = rf_waddr;
        o.a_ld   = a_ld;
        o.g_ld   = g_ld;
        o.g_oe   = g_oe;
        o.alu_op = alu_op;
        return o;
    endfunction

    // Idle record for a given step and IR: no strobes, immediate reflects IR when ADDI is built in
    function automatic outs_t base(input logic [1:0] t, input logic [9:0] ir);
        outs_t o;
        o = '0;
        o.tstep = t;
        o.ir    = ir;
`ifdef SEQ_ADDI_EN
        o.imm   = {6'b0, ir[3:0]};
`endif
        return o;
    endfunction

    task automatic push_alu3(input logic [9:0] ir, input logic [2:0] op, input bit use_imm);
        outs_t o;
        o = base(2'd1, ir); o.rf_oe = 1'b1; o.raddr = ir[5:4]; o.a_ld = 1'b1;
        sb.push_back(o);
        o = base(2'd2, ir); o.g_ld = 1'b1; o.alu_op = op;
        if (use_imm) o.imm_oe = 1'b1;
        else begin o.rf_oe = 1'b1; o.raddr = ir[3:2]; end
        sb.push_back(o);
        o = base(2'd3, ir); o.g_oe = 1'b1; o.rf_we = 1'b1; o.waddr = ir[5:4]; o.done = 1'b1;
        sb.push_back(o);
    endtask

    // Expected outputs for every step of one instruction, then the T0 cycle that follows
    task automatic push_expected(input logic [9:0] ir);
        outs_t o;
        case (ir[9:6])
            4'b0000: begin
                o = base(2'd1, ir); o.ext_oe = 1'b1; o.rf_we = 1'b1; o.waddr = ir[5:4]; o.done = 1'b1;
                sb.push_back(o);
            end
            4'b0001: begin
                o = base(2'd1, ir); o.rf_oe = 1'b1; o.raddr = ir[3:2];
                o.rf_we = 1'b1; o.waddr = ir[5:4]; o.done = 1'b1;
                sb.push_back(o);
            end
            4'b0010: push_alu3(ir, 3'b000, 1'b0);
            4'b0011: push_alu3(ir, 3'b001, 1'b0);
            4'b0101: push_alu3(ir, 3'b011, 1'b0);
            4'b0110: push_alu3(ir, 3'b100, 1'b0);
            4'b0111: push_alu3(ir, 3'b101, 1'b0);
            4'b0100: begin
                o = base(2'd1, ir); o.rf_oe = 1'b1; o.raddr = ir[3:2]; o.g_ld = 1'b1; o.alu_op = 3'b010;
                sb.push_back(o);
                o = base(2'd2, ir); o.g_oe = 1'b1; o.rf_we = 1'b1; o.waddr = ir[5:4]; o.done = 1'b1;
                sb.push_back(o);
            end
`ifdef SEQ_ADDI_EN
            4'b1000: push_alu3(ir, 3'b000, 1'b1);
`endif
            default: begin
                o = base(2'd1, ir); o.done = 1'b1;
                sb.push_back(o);
            end
        endcase
        sb.push_back(base(2'd0, ir));
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Advance one cycle, sample at the falling edge, check bus exclusivity and the scoreboard head
    task automatic tick();
        outs_t exp;
        @(negedge clk);
        cur = sample();
        checks++;
        if ($countones({cur.ext_oe, cur.imm_oe, cur.rf_oe, cur.g_oe}) > 1) begin
            errors++;
            $display("FAIL bus_excl: got drivers %b expected at most one", {cur.ext_oe, cur.imm_oe, cur.rf_oe, cur.g_oe});
        end
        if (cur.done) done_seen++;
        if (sb.size() > 0) begin
            exp = sb.pop_front();
            checks++;
            if (cur !== exp) begin
                errors++;
                $display("FAIL step_outputs t=%0d: got %h expected %h", exp.tstep, cur, exp);
            end
        end
    endtask

    // Issue one instruction; optionally keep EXEC pulsing with other data while it is busy
    task automatic run_instr(input logic [9:0] word, input bit spurious, output int unsigned lat);
        int unsigned k;
        exec = 1'b1;
        din  = word;
        push_expected(word);
        lat = 0;
        k   = 0;
        while (sb.size() > 0 && k < 8) begin
            tick();
            k++;
            if (cur.done && lat == 0) lat = k;
            if (sb.size() > 0 && spurious) begin
                exec = 1'b1;
                din  = ~word;
            end else begin
                exec = 1'b0;
                din  = 10'($urandom);
            end
        end
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: got %0d pending records expected 0", sb.size());
            sb.delete();
        end
    endtask

    vec_t vecs[12];

    initial begin
        int unsigned lat;
        int          done_before;
        logic [9:0]  sub_word;

        checks    = 0;
        errors    = 0;
        done_seen = 0;
        rst  = 1'b1;
        exec = 1'b0;
        din  = '0;

        vecs[0]  = '{10'b0000_10_0000, 1};
        vecs[1]  = '{10'b0010_01_1100, 3};
        vecs[2]  = '{10'b0001_11_0100, 1};
        vecs[3]  = '{10'b0011_10_0100, 3};
        vecs[4]  = '{10'b0100_01_1000, 2};
        vecs[5]  = '{10'b0101_00_0100, 3};
        vecs[6]  = '{10'b0110_11_0000, 3};
        vecs[7]  = '{10'b0111_10_1100, 3};
`ifdef SEQ_ADDI_EN
        vecs[8]  = '{10'b1000_00_0111, 3};
`else
        vecs[8]  = '{10'b1000_00_0111, 1};
`endif
        vecs[9]  = '{10'b1111_11_1111, 1};
        vecs[10] = '{10'b1001_01_0110, 1};
        vecs[11] = '{10'b0000_11_1111, 1};

        repeat (2) @(negedge clk);
        cur = sample();
        chk("reset_hold", 32'(cur), 32'(base(2'd0, 10'd0)));
        rst = 1'b0;
        tick();
        chk("reset_idle", 32'(cur), 32'(base(2'd0, 10'd0)));

        foreach (vecs[i]) begin
            run_instr(vecs[i].din, 1'b0, lat);
            chk($sformatf("latency_%0d", i), lat, vecs[i].lat);
            chk($sformatf("ir_hold_%0d", i), ir_q, vecs[i].din);
        end

        // Extra EXEC pulses while an ADD is in flight must be ignored
        run_instr(10'b0010_01_1100, 1'b1, lat);
        chk("add_spurious_latency", lat, 3);

        // Reset in T2 of a SUB abandons it with no register write
        sub_word = 10'b0011_01_1000;
        exec = 1'b1;
        din  = sub_word;
        tick();
        exec = 1'b0;
        chk("sub_t1_time", tstep, 2'd1);
        tick();
        chk("sub_t2_gld", {g_ld, rf_oe, rf_raddr}, {1'b1, 1'b1, 2'd2});
        rst = 1'b1;
        #1;
        chk("rst_forces_zero", 32'(sample()), 32'(base(2'd2, sub_word)));
        tick();
        chk("rst_clears", 32'(cur), 32'(base(2'd0, 10'd0)));
        rst = 1'b0;
        repeat (3) begin
            tick();
            chk("rst_no_write", 32'(cur), 32'(base(2'd0, 10'd0)));
        end

        // Random stream of legal and illegal instructions
        done_before = done_seen;
        for (int unsigned n = 0; n < 200; n++) begin
            run_instr(10'($urandom), 1'($urandom_range(0, 1)), lat);
            repeat ($urandom_range(0, 2)) tick();
        end
        chk("random_done_count", 32'(done_seen - done_before), 32'd200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish within time limit");
        $fatal(1);
    end

endmodule
